// File: rtl/vec_pkg.sv
// Shared types and sizing for the vector store path.
// Contents: LANES/DATA_W/ADDR_W defaults, lane-index width, vector and
// address typedefs, and the store sequencer state encoding.
// Optional feature macro used by vec_store_seq: VSTORE_MASK_EN.
package vec_pkg;

  localparam int LANES  = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int IDX_W  = $clog2(LANES);

  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;
  typedef logic [ADDR_W-1:0]            addr_t;
  typedef logic [DATA_W-1:0]            elem_t;
  typedef logic [IDX_W-1:0]             idx_t;

  typedef enum logic [1:0] {
    VST_IDLE  = 2'd0,
    VST_WRITE = 2'd1,
    VST_DONE  = 2'd2
  } vst_state_t;

endpackage

// File: rtl/vst_addr_gen.sv
// Address generator for the vector store sequencer.
// Holds the captured base address and the current lane index, and
// produces base+idx (ADDR_W-bit wrap, carry dropped) plus a last-lane flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       capture i_base and clear the lane index
//   i_base       element-0 address
//   i_advance    step to the next lane
//   o_addr       base + idx
//   o_idx        current lane index
//   o_last       idx == LANES-1
module vst_addr_gen
  import vec_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_load,
  input  addr_t i_base,
  input  logic  i_advance,
  output addr_t o_addr,
  output idx_t  o_idx,
  output logic  o_last
);

  addr_t r_base;
  idx_t  r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_idx  <= '0;
    end else if (i_advance) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Unsigned add at ADDR_W bits; overflow past the top of memory wraps to 0.
  assign o_addr = r_base + addr_t'(r_idx);
  assign o_idx  = r_idx;
  assign o_last = (r_idx == idx_t'(LANES - 1));

endmodule

// File: rtl/vec_store_seq.sv
// Vector store sequencer: captures one LANES-wide vector and a base
// address, then issues one element write per lane at base+0..base+LANES-1
// on a single-port memory, stalling on mem_gnt_i, and pulses done_o once.
// Optional feature macro: VSTORE_MASK_EN (adds mask_i; masked-off lanes
// take one cycle with no write and no wait for grant).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             store request, accepted when ready_o=1
//   base_i, vdata_i     address / payload, sampled on accept
//   mask_i              per-lane write enable (VSTORE_MASK_EN only)
//   ready_o, done_o     idle indication / one-cycle completion pulse
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_gnt_i   memory write port
module vec_store_seq
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  addr_t            base_i,
  input  vec_t             vdata_i,
`ifdef VSTORE_MASK_EN
  input  logic [LANES-1:0] mask_i,
`endif
  output logic             ready_o,
  output logic             done_o,
  output logic             mem_we_o,
  output addr_t            mem_addr_o,
  output elem_t            mem_wdata_o,
  input  logic             mem_gnt_i
);

  vst_state_t r_state;
  vec_t       r_vdata;

  logic  w_load;
  logic  w_advance;
  logic  w_lane_en;
  logic  w_we;
  logic  w_last;
  addr_t w_addr;
  idx_t  w_idx;

  assign w_load = (r_state == VST_IDLE) && start_i;

`ifdef VSTORE_MASK_EN
  logic [LANES-1:0] r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_mask <= '0;
    else if (w_load) r_mask <= mask_i;
  end

  assign w_lane_en = r_mask[w_idx];
`else
  assign w_lane_en = 1'b1;
`endif

  // A disabled lane never waits for grant, so it always costs one cycle.
  assign w_advance = (r_state == VST_WRITE) && (w_lane_en ? mem_gnt_i : 1'b1);

  vst_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_base    (base_i),
    .i_advance (w_advance),
    .o_addr    (w_addr),
    .o_idx     (w_idx),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= VST_IDLE;
      r_vdata <= '0;
    end else begin
      case (r_state)
        VST_IDLE: begin
          if (start_i) begin
            r_state <= VST_WRITE;
            r_vdata <= vdata_i;
          end
        end
        VST_WRITE: begin
          if (w_advance && w_last) r_state <= VST_DONE;
        end
        VST_DONE: r_state <= VST_IDLE;
        default:  r_state <= VST_IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state so the asynchronous
  // reset clears them immediately; address/data are forced to 0 when idle.
  assign w_we        = (r_state == VST_WRITE) && w_lane_en;
  assign mem_we_o    = w_we;
  assign mem_addr_o  = w_we ? w_addr : '0;
  assign mem_wdata_o = w_we ? r_vdata[w_idx] : '0;
  assign ready_o     = (r_state == VST_IDLE);
  assign done_o      = (r_state == VST_DONE);

endmodule
